// File: rtl/pipeline_commit_monitor_if.sv
// Commit-monitor bus: pipeline taps, expected-table load, trace readout and check status.
// master drives the taps and consumes the trace; slave is the monitor itself.
interface pipeline_commit_monitor_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CYC_WIDTH      = 16
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int FC_W     = $clog2(NUM_REGS + 1);

    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_write_register;
    logic [DATA_WIDTH-1:0]     wb_write_data;
    logic                      mem_mem_write;
    logic [DATA_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_write_data;
    logic                      exp_wr_en;
    logic [REG_ADDR_WIDTH-1:0] exp_addr;
    logic [DATA_WIDTH-1:0]     exp_data;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [2*DATA_WIDTH:0]     rd_data;
    logic                      overflow;
    logic [CYC_WIDTH-1:0]      cycle_count;
    logic                      done;
    logic                      pass;
    logic [FC_W-1:0]           fail_count;
    logic [REG_ADDR_WIDTH-1:0] first_fail;

    modport master (
        output wb_reg_write, wb_write_register, wb_write_data,
        output mem_mem_write, mem_addr, mem_write_data,
        output exp_wr_en, exp_addr, exp_data,
        output rd_ready,
        input  rd_valid, rd_data, overflow, cycle_count, done, pass, fail_count, first_fail
    );

    modport slave (
        input  wb_reg_write, wb_write_register, wb_write_data,
        input  mem_mem_write, mem_addr, mem_write_data,
        input  exp_wr_en, exp_addr, exp_data,
        input  rd_ready,
        output rd_valid, rd_data, overflow, cycle_count, done, pass, fail_count, first_fail
    );
endinterface

// File: rtl/pipeline_commit_monitor.sv
// Shadow regfile + drop-on-full commit trace, checked against an expected table at CHECK_CYCLE; store tracing via COMMIT_MON_STORE_TRACE_EN.
// Trace head visible one cycle after a commit; entries that find no free slot are dropped and flagged in overflow.
module pipeline_commit_monitor #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TRACE_DEPTH    = 16,
    parameter int CYC_WIDTH      = 16,
    parameter int CHECK_CYCLE    = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    pipeline_commit_monitor_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int FC_W     = $clog2(NUM_REGS + 1);
    localparam int ENT_W    = 1 + 2 * DATA_WIDTH;
    localparam int PTR_W    = $clog2(TRACE_DEPTH);
    localparam int CNT_W    = $clog2(TRACE_DEPTH + 1);

    typedef enum logic [1:0] {RUN, CHECK, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CYC_WIDTH-1:0]      cycle_q, cycle_d;
    logic [REG_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [FC_W-1:0]           fail_q, fail_d;
    logic [REG_ADDR_WIDTH-1:0] first_q, first_d;

    logic [DATA_WIDTH-1:0]     shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     exp_q    [NUM_REGS];
    logic [NUM_REGS-1:0]       exp_vld_q;
    logic                      shadow_we, exp_we;

    logic [ENT_W-1:0]          fifo_q [TRACE_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, free_slots;
    logic                      ovf_q, ovf_d;
    logic                      pop, push_wb, push_st;
    logic [ENT_W-1:0]          wb_ent;

    // Register 0 is hardwired in the pipeline, so its commits are traced but never shadowed.
    assign shadow_we = (state_q == RUN) && bus.wb_reg_write && (bus.wb_write_register != '0);
    assign exp_we    = (state_q != CHECK) && bus.exp_wr_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                exp_q[i]    <= '0;
            end
            exp_vld_q <= '0;
        end else begin
            if (shadow_we) shadow_q[bus.wb_write_register] <= bus.wb_write_data;
            if (exp_we) begin
                exp_q[bus.exp_addr]     <= bus.exp_data;
                exp_vld_q[bus.exp_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        first_d = first_q;
        cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + CYC_WIDTH'(1);
        case (state_q)
            RUN: begin
                if (cycle_q == CYC_WIDTH'(CHECK_CYCLE)) state_d = CHECK;
            end
            CHECK: begin
                idx_d = idx_q + REG_ADDR_WIDTH'(1);
                if (exp_vld_q[idx_q] && (shadow_q[idx_q] != exp_q[idx_q])) begin
                    fail_d = fail_q + FC_W'(1);
                    if (fail_q == '0) first_d = idx_q;
                end
                if (idx_q == REG_ADDR_WIDTH'(NUM_REGS - 1)) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    assign wb_ent = {1'b0, DATA_WIDTH'(bus.wb_write_register), bus.wb_write_data};

    // Free space counts a same-cycle pop so a full FIFO being drained still accepts a commit.
    always_comb begin
        pop        = (cnt_q != '0) && bus.rd_ready;
        free_slots = CNT_W'(TRACE_DEPTH) - cnt_q + CNT_W'(pop);
        push_wb    = bus.wb_reg_write && (free_slots != '0);
`ifdef COMMIT_MON_STORE_TRACE_EN
        push_st    = bus.mem_mem_write &&
                     (free_slots > (bus.wb_reg_write ? CNT_W'(1) : CNT_W'(0)));
        ovf_d      = ovf_q | (bus.wb_reg_write & ~push_wb) | (bus.mem_mem_write & ~push_st);
`else
        push_st    = 1'b0;
        ovf_d      = ovf_q | (bus.wb_reg_write & ~push_wb);
`endif
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_wb) + PTR_W'(push_st);
        cnt_d      = cnt_q + CNT_W'(push_wb) + CNT_W'(push_st) - CNT_W'(pop);
    end

`ifdef COMMIT_MON_STORE_TRACE_EN
    logic [ENT_W-1:0] st_ent;
    assign st_ent = {1'b1, bus.mem_addr, bus.mem_write_data};
`else
    logic unused_store;
    assign unused_store = ^{bus.mem_mem_write, bus.mem_addr, bus.mem_write_data};
`endif

    always_ff @(posedge clk) begin
        if (reset && push_wb) fifo_q[wr_ptr_q] <= wb_ent;
`ifdef COMMIT_MON_STORE_TRACE_EN
        if (reset && push_st) fifo_q[wr_ptr_q + PTR_W'(push_wb)] <= st_ent;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RUN;
            cycle_q  <= '0;
            idx_q    <= '0;
            fail_q   <= '0;
            first_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            first_q  <= first_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.rd_valid    = (cnt_q != '0);
    assign bus.rd_data     = (cnt_q != '0) ? fifo_q[rd_ptr_q] : '0;
    assign bus.overflow    = ovf_q;
    assign bus.cycle_count = cycle_q;
    assign bus.done        = (state_q == DONE);
    assign bus.pass        = (state_q == DONE) && (fail_q == '0);
    assign bus.fail_count  = fail_q;
    assign bus.first_fail  = first_q;
endmodule

// File: tb/tb_pipeline_commit_monitor.sv
// Directed + random stimulus for pipeline_commit_monitor against a cycle-indexed reference model.
module tb_pipeline_commit_monitor;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int NR     = 32;
    localparam int DEPTH  = 16;
    localparam int CHK    = 40;
    localparam int DONE_T = CHK + NR + 1;
`ifdef COMMIT_MON_STORE_TRACE_EN
    localparam bit STORE_EN = 1'b1;
`else
    localparam bit STORE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_commit_monitor_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CYC_WIDTH(16)) bus ();

    pipeline_commit_monitor #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .TRACE_DEPTH(DEPTH),
        .CYC_WIDTH(16), .CHECK_CYCLE(CHK)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    // Reference model: t is the cycle_count value of the current cycle.
    int          t;
    logic [31:0] m_shadow [NR];
    logic [31:0] m_exp    [NR];
    bit          m_vld    [NR];
    logic [64:0] m_q [$];
    bit          m_ovf;
    int          r_fail, r_first;
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic logic [64:0] ent(input logic kind, input logic [31:0] a, input logic [31:0] d);
        return {kind, a, d};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expv, t);
    endtask

    task automatic check_outputs();
        chk("rd_valid", 65'(bus.rd_valid), 65'(m_q.size() != 0));
        if (m_q.size() != 0) chk("rd_data", bus.rd_data, m_q[0]);
        chk("overflow", 65'(bus.overflow), 65'(m_ovf));
        chk("done", 65'(bus.done), 65'(t >= DONE_T));
        if (t <= CHK + 1) begin
            chk("cycle_count", 65'(bus.cycle_count), 65'(t));
            chk("pass_pre", 65'(bus.pass), 65'(0));
            chk("fail_pre", 65'(bus.fail_count), 65'(0));
            chk("first_pre", 65'(bus.first_fail), 65'(0));
        end else if (t >= DONE_T) begin
            chk("pass", 65'(bus.pass), 65'(r_fail == 0));
            chk("fail_count", 65'(bus.fail_count), 65'(r_fail));
            chk("first_fail", 65'(bus.first_fail), 65'(r_first));
        end
    endtask

    // Apply the current inputs for one clock, advance the model, then compare.
    task automatic cyc();
        int free;
        if (!rst_n) begin
            t = 0; m_ovf = 0; r_fail = 0; r_first = 0;
            m_q.delete();
            for (int i = 0; i < NR; i++) begin
                m_shadow[i] = '0; m_exp[i] = '0; m_vld[i] = 0;
            end
        end else begin
            if (bus.wb_reg_write && t <= CHK && bus.wb_write_register != 0)
                m_shadow[bus.wb_write_register] = bus.wb_write_data;
            if (bus.exp_wr_en && (t <= CHK || t >= DONE_T)) begin
                m_exp[bus.exp_addr] = bus.exp_data;
                m_vld[bus.exp_addr] = 1;
            end
            if (t == CHK) begin
                r_fail = 0; r_first = 0;
                for (int i = 0; i < NR; i++)
                    if (m_vld[i] && m_shadow[i] !== m_exp[i]) begin
                        if (r_fail == 0) r_first = i;
                        r_fail++;
                    end
            end
            if (bus.rd_ready && m_q.size() > 0) void'(m_q.pop_front());
            free = DEPTH - m_q.size();
            if (bus.wb_reg_write) begin
                if (free > 0) begin
                    m_q.push_back(ent(1'b0, 32'(bus.wb_write_register), bus.wb_write_data));
                    free--;
                end else m_ovf = 1;
            end
            if (STORE_EN && bus.mem_mem_write) begin
                if (free > 0) m_q.push_back(ent(1'b1, bus.mem_addr, bus.mem_write_data));
                else m_ovf = 1;
            end
            if (t < 65535) t++;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        bus.wb_reg_write = 1'b0; bus.mem_mem_write = 1'b0; bus.exp_wr_en = 1'b0;
    endtask

    task automatic set_wb(input int r, input int d);
        bus.wb_reg_write = 1'b1; bus.wb_write_register = 5'(r); bus.wb_write_data = 32'(d);
    endtask

    task automatic set_exp(input int a, input int d);
        bus.exp_wr_en = 1'b1; bus.exp_addr = 5'(a); bus.exp_data = 32'(d);
    endtask

    task automatic set_store(input int a, input int d);
        bus.mem_mem_write = 1'b1; bus.mem_addr = 32'(a); bus.mem_write_data = 32'(d);
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic run_to(input int n);
        while (t < n) cyc();
    endtask

    task automatic prog(input bit bad);
        int vals [5];
        vals = '{5, 10, 100, 20, 15};
        for (int k = 0; k < 5; k++) begin
            set_wb(k + 1, vals[k]);
            set_exp(k + 1, (bad && k == 2) ? 99 : vals[k]);
            cyc();
        end
        if (bad) begin
            set_wb(7, 0);
            set_exp(7, 1);
            cyc();
        end
        idle();
    endtask

    initial begin
        idle();
        bus.wb_write_register = '0; bus.wb_write_data = '0;
        bus.mem_addr = '0; bus.mem_write_data = '0;
        bus.exp_addr = '0; bus.exp_data = '0;
        bus.rd_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_cycle", 65'(bus.cycle_count), 65'(0));
        chk("rst_rd_valid", 65'(bus.rd_valid), 65'(0));

        // Matching program: pass at exactly cycle 73.
        reset_dut();
        bus.rd_ready = 1'b1;
        prog(1'b0);
        run_to(DONE_T - 1);
        chk("t1_done_early", 65'(bus.done), 65'(0));
        cyc();
        chk("t1_done", 65'(bus.done), 65'(1));
        chk("t1_pass", 65'(bus.pass), 65'(1));
        chk("t1_fail", 65'(bus.fail_count), 65'(0));

        // Two mismatches: exp[3]=99 and exp[7]=1 against $7=0.
        reset_dut();
        prog(1'b1);
        run_to(DONE_T);
        chk("t2_pass", 65'(bus.pass), 65'(0));
        chk("t2_fail", 65'(bus.fail_count), 65'(2));
        chk("t2_first", 65'(bus.first_fail), 65'(3));

        // 20 commits into a 16-deep trace with no reader, then drain.
        reset_dut();
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_wb(k + 1, 1000 + k);
            cyc();
        end
        idle();
        chk("t3_overflow", 65'(bus.overflow), 65'(1));
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t3_drain", bus.rd_data, ent(1'b0, 32'(k + 1), 32'(1000 + k)));
            cyc();
        end
        chk("t3_empty", 65'(bus.rd_valid), 65'(0));

        // $0 commit traced but not shadowed; then one-free-slot WB+store race.
        reset_dut();
        bus.rd_ready = 1'b1;
        set_wb(0, 7);
        set_exp(0, 0);
        cyc();
        idle();
        chk("t5_r0_entry", bus.rd_data, ent(1'b0, 32'd0, 32'd7));
        cyc();
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            set_wb(k + 1, k);
            cyc();
        end
        set_wb(5, 15);
        set_store(100, 15);
        cyc();
        idle();
        chk("t4_overflow", 65'(bus.overflow), 65'(STORE_EN));
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 15; k++) cyc();
        chk("t4_last_wb", bus.rd_data, ent(1'b0, 32'd5, 32'd15));
        cyc();
        set_store(200, 42);
        cyc();
        idle();
        chk("t4_store_vis", 65'(bus.rd_valid), 65'(STORE_EN));
        run_to(DONE_T);
        chk("t5_pass", 65'(bus.pass), 65'(1));

        // Reset in the 10th CHECK cycle discards the partial result and the table.
        reset_dut();
        set_wb(1, 5);
        set_exp(1, 6);
        cyc();
        idle();
        run_to(CHK + 10);
        chk("t6_partial", 65'(bus.fail_count), 65'(1));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t6_done", 65'(bus.done), 65'(0));
        chk("t6_fail", 65'(bus.fail_count), 65'(0));
        chk("t6_cycle", 65'(bus.cycle_count), 65'(0));
        chk("t6_empty", 65'(bus.rd_valid), 65'(0));
        set_wb(1, 5);
        cyc();
        idle();
        run_to(DONE_T);
        chk("t6_vld_cleared", 65'(bus.pass), 65'(1));

        // Random traffic across RUN, CHECK and DONE.
        for (int run = 0; run < 2; run++) begin
            reset_dut();
            for (int k = 0; k < 85; k++) begin
                bus.wb_reg_write      = 1'($urandom_range(0, 1));
                bus.wb_write_register = 5'($urandom_range(0, 31));
                bus.wb_write_data     = 32'($urandom_range(0, 3));
                bus.mem_mem_write     = ($urandom_range(0, 3) == 0);
                bus.mem_addr          = $urandom;
                bus.mem_write_data    = $urandom;
                bus.exp_wr_en         = ($urandom_range(0, 2) == 0);
                bus.exp_addr          = 5'($urandom_range(0, 31));
                bus.exp_data          = 32'($urandom_range(0, 3));
                bus.rd_ready          = 1'($urandom_range(0, 1));
                cyc();
            end
            idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipeline_commit_monitor.md
# pipeline_commit_monitor

Parametrised, synthesizable commit monitor for the MIPS pipeline. It taps the WB write port and the MEM store port, and keeps a shadow register file plus a drop-on-full trace FIFO of commits. At a programmed cycle it checks the shadow file against a loadable expected-value table and reports pass/fail. It replaces hard-coded cycle-40 register dumps with an on-chip checker, usable both in simulation and on FPGA through the trace readout port.

## Interface
- DATA_WIDTH, 32, register and memory data width
- REG_ADDR_WIDTH, 5, register index width; NUM_REGS = 2**REG_ADDR_WIDTH
- TRACE_DEPTH, 16, trace FIFO entries, power of two, ≥2
- CYC_WIDTH, 16, cycle counter width
- CHECK_CYCLE, 40, cycle_count value that triggers the check
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- wb_reg_write  in  1  WB commit strobe
- wb_write_register  in  REG_ADDR_WIDTH  WB destination
- wb_write_data  in  DATA_WIDTH  WB data
- mem_mem_write  in  1  store strobe
- mem_addr  in  DATA_WIDTH  store byte address
- mem_write_data  in  DATA_WIDTH  store data
- exp_wr_en  in  1  expected-table write
- exp_addr  in  REG_ADDR_WIDTH  expected-table index
- exp_data  in  DATA_WIDTH  expected value; write sets the entry's valid bit
- rd_valid  out  1  trace head available
- rd_ready  in  1  trace consumer ready
- rd_data  out  1+2*DATA_WIDTH  {kind(0=reg,1=store), addr zero-extended, data}
- overflow  out  1  sticky: at least one trace entry dropped
- cycle_count  out  CYC_WIDTH  cycles since reset release, saturating
- done  out  1  check complete
- pass  out  1  done and fail_count==0
- fail_count  out  clog2(NUM_REGS+1)  mismatching valid entries
- first_fail  out  REG_ADDR_WIDTH  lowest mismatching index; 0 if none

## Operation
- FSM states: RUN, CHECK, DONE. Reset forces RUN.
- Reset values: all outputs 0; shadow file 0; expected valid bits 0; FIFO empty.
- RUN behaviour:
  - cycle_count increments each cycle. It is 1 in the first cycle after reset deasserts and saturates at all-ones.
  - WB commit (wb_reg_write=1) updates shadow[wb_write_register] with wb_write_data. Register 0 is never updated, but its commit is still traced.
  - When cycle_count==CHECK_CYCLE, the FSM moves to CHECK. The shadow file freezes from the first CHECK cycle.
- CHECK behaviour:
  - Index i runs 0..NUM_REGS-1, one entry per cycle.
  - When valid[i] is set and shadow[i]!=exp[i]: fail_count increments; first_fail=i on the first mismatch.
  - After i=NUM_REGS-1 the FSM moves to DONE.
- DONE behaviour: done=1; pass=(fail_count==0). The FSM holds DONE until reset.
- Expected table: written in RUN and DONE; writes during CHECK are ignored. An index that is never written is not checked.
- Trace: active in all states.
  - Same-cycle WB and store commits push the WB entry first, then the store entry.
  - Free slots = TRACE_DEPTH − count + (rd_valid&rd_ready).
  - Entries beyond the free slots are dropped, and overflow is set; the store entry is dropped first.
- Readout:
  - rd_valid = FIFO non-empty.
  - rd_data = head entry.
  - A pop occurs on rd_valid&rd_ready.
  - rd_data stays stable while rd_valid=1 and rd_ready=0.
- Pointers wrap modulo TRACE_DEPTH; count is held in a separate register so that the full and empty conditions are unambiguous.

## Timing
- Shadow update: a commit in cycle n is visible to the check from cycle n+1.
- Trace latency: a commit in cycle n gives rd_valid=1 in cycle n+1 when the FIFO was empty.
- Check latency: CHECK occupies NUM_REGS cycles. done rises NUM_REGS+1 cycles after the cycle in which cycle_count==CHECK_CYCLE.
- Reset low mid-CHECK, or at any time: every register returns to its reset value at the next edge, and any partial result is discarded.
- rd_ready may be held high permanently; back-to-back pops take 1 per cycle.

## Configuration
- COMMIT_MON_STORE_TRACE_EN defined: store commits are pushed into the trace as kind=1 entries.
- COMMIT_MON_STORE_TRACE_EN undefined:
  - mem_mem_write, mem_addr and mem_write_data are ignored.
  - Only WB commits are traced.
  - The push logic is single-port, so WB entries are never dropped because of a store.

## Test plan
- Program commits $1=5, $2=10, $3=100, $4=20, $5=15, with expected values loaded to match -> done after cycle 40+32+1, pass=1, fail_count=0.
- Same program with exp[3]=99 and exp[7]=1 while $7 commits 0 -> pass=0, fail_count=2, first_fail=3.
- 20 WB commits with rd_ready=0 (TRACE_DEPTH=16) -> 16 entries retained, overflow=1; a later drain returns the first 16 commits in order.
- Same-cycle WB $5=15 and store Mem[100]=15 with one free slot -> WB entry kept, store dropped, overflow=1. Without the macro, the store is never traced.
- Commit to $0 with data 7 -> trace entry {0,0,7} present; shadow[0] stays 0, and exp[0]=0 passes.
- Reset asserted at the 10th CHECK cycle -> next cycle: done=0, fail_count=0, cycle_count=0, FIFO empty, expected valid bits cleared.
